// File: rtl/lim_switch_debounce.sv
// Per-bit debouncer and sticky edge-event latch for the scanned limit-switch image.
// Latency: stable_state/rise_evt/fall_evt/changed one cycle after sample_valid; irq one more cycle.
// Backpressure: none; every sample_valid cycle is consumed as one scan.
// Optional: LIM_DEB_GLITCH_CNT_EN adds glitch_cnt/glitch_clr (rejected-bounce counter).
module lim_switch_debounce #(
    parameter int   LIM_BITS   = 48,
    parameter int   DEB_SCANS  = 4,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic                sys_clock,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [LIM_BITS-1:0] sample_data,
    input  logic                clr_we,
    input  logic [LIM_BITS-1:0] clr_mask,
    input  logic [LIM_BITS-1:0] irq_mask,
    output logic [LIM_BITS-1:0] stable_state,
    output logic [LIM_BITS-1:0] rise_evt,
    output logic [LIM_BITS-1:0] fall_evt,
    output logic                changed,
    output logic                irq
`ifdef LIM_DEB_GLITCH_CNT_EN
    ,
    output logic [15:0]         glitch_cnt,
    input  logic                glitch_clr
`endif
);

    // Count value at which one more disagreeing scan flips the stable bit.
    localparam logic [3:0] CNT_LAST = 4'(DEB_SCANS - 1);

    logic [LIM_BITS-1:0] stable_q, stable_d;
    logic [LIM_BITS-1:0] rise_q, rise_d;
    logic [LIM_BITS-1:0] fall_q, fall_d;
    logic [3:0]          cnt_q [LIM_BITS];
    logic [3:0]          cnt_d [LIM_BITS];
    logic                changed_q, changed_d;
    logic                irq_q, irq_d;

    // Per-bit debounce counters, level toggling and event set/clear (set applied last so it wins).
    always_comb begin
        stable_d  = stable_q;
        rise_d    = rise_q;
        fall_d    = fall_q;
        changed_d = 1'b0;
        for (int i = 0; i < LIM_BITS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (clr_we) begin
            rise_d = rise_q & ~clr_mask;
            fall_d = fall_q & ~clr_mask;
        end
        if (sample_valid) begin
            for (int i = 0; i < LIM_BITS; i++) begin
                if (sample_data[i] == stable_q[i]) begin
                    cnt_d[i] = 4'd0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = ~stable_q[i];
                    cnt_d[i]    = 4'd0;
                    changed_d   = 1'b1;
                    if (sample_data[i]) begin
                        rise_d[i] = 1'b1;
                    end else begin
                        fall_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
        // Interrupt is taken from the registered events, so it trails them by a cycle.
        irq_d = |((rise_q | fall_q) & irq_mask);
    end

    // State registers with synchronous reset.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            stable_q  <= {LIM_BITS{INIT_LEVEL}};
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            irq_q     <= 1'b0;
            for (int i = 0; i < LIM_BITS; i++) begin
                cnt_q[i] <= 4'd0;
            end
        end else begin
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            irq_q     <= irq_d;
            for (int i = 0; i < LIM_BITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stable_state = stable_q;
    assign rise_evt     = rise_q;
    assign fall_evt     = fall_q;
    assign changed      = changed_q;
    assign irq          = irq_q;

`ifdef LIM_DEB_GLITCH_CNT_EN
    logic        glitch_hit;
    logic [15:0] glitch_q, glitch_d;

    // A bounce is rejected when a partially counted bit sees its stable level again.
    always_comb begin
        glitch_hit = 1'b0;
        for (int i = 0; i < LIM_BITS; i++) begin
            if ((cnt_q[i] != 4'd0) && (sample_data[i] == stable_q[i])) begin
                glitch_hit = 1'b1;
            end
        end
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = 16'd0;
        end else if (sample_valid && glitch_hit && (glitch_q != 16'hFFFF)) begin
            glitch_d = glitch_q + 16'd1;
        end
    end

    // Saturating glitch counter; clear beats a same-cycle increment.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            glitch_q <= 16'd0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_lim_switch_debounce.sv
// Directed self-checking bench for lim_switch_debounce (DEB_SCANS=4 main DUT, DEB_SCANS=1 side DUT).
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Expected values are hand-derived constants.
module tb_lim_switch_debounce;

    localparam int W = 48;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sample_valid = 1'b0;
    logic [W-1:0] sample_data = '0;
    logic         clr_we = 1'b0;
    logic [W-1:0] clr_mask = '0;
    logic [W-1:0] irq_mask = '0;
    logic [W-1:0] stable_state, rise_evt, fall_evt;
    logic         changed, irq;

    logic         b_valid = 1'b0;
    logic [W-1:0] b_data = '0;
    logic [W-1:0] b_stable, b_rise, b_fall;
    logic         b_changed, b_irq;

`ifdef LIM_DEB_GLITCH_CNT_EN
    logic [15:0]  glitch_cnt, b_glitch_cnt;
    logic         glitch_clr = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lim_switch_debounce #(.LIM_BITS(W), .DEB_SCANS(4), .INIT_LEVEL(1'b0)) dut (
        .sys_clock    (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .clr_we       (clr_we),
        .clr_mask     (clr_mask),
        .irq_mask     (irq_mask),
        .stable_state (stable_state),
        .rise_evt     (rise_evt),
        .fall_evt     (fall_evt),
        .changed      (changed),
        .irq          (irq)
`ifdef LIM_DEB_GLITCH_CNT_EN
        ,
        .glitch_cnt   (glitch_cnt),
        .glitch_clr   (glitch_clr)
`endif
    );

    lim_switch_debounce #(.LIM_BITS(W), .DEB_SCANS(1), .INIT_LEVEL(1'b0)) dut1 (
        .sys_clock    (clk),
        .reset        (reset),
        .sample_valid (b_valid),
        .sample_data  (b_data),
        .clr_we       (1'b0),
        .clr_mask     ({W{1'b0}}),
        .irq_mask     ({W{1'b0}}),
        .stable_state (b_stable),
        .rise_evt     (b_rise),
        .fall_evt     (b_fall),
        .changed      (b_changed),
        .irq          (b_irq)
`ifdef LIM_DEB_GLITCH_CNT_EN
        ,
        .glitch_cnt   (b_glitch_cnt),
        .glitch_clr   (1'b0)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One scan on the main DUT; outputs reflect it on return.
    task automatic scan(input logic [W-1:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (stable_state !== 48'h0) begin n_fail++; $display("FAIL reset_stable got=%h exp=%h", stable_state, 48'h0); end
        n_checks++; if (rise_evt !== 48'h0) begin n_fail++; $display("FAIL reset_rise got=%h exp=%h", rise_evt, 48'h0); end
        n_checks++; if (fall_evt !== 48'h0) begin n_fail++; $display("FAIL reset_fall got=%h exp=%h", fall_evt, 48'h0); end
        n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed got=%b exp=0", changed); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", irq); end
        n_checks++; if (b_stable !== 48'h0) begin n_fail++; $display("FAIL reset_b_stable got=%h exp=%h", b_stable, 48'h0); end
`ifdef LIM_DEB_GLITCH_CNT_EN
        n_checks++; if (glitch_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_glitch got=%0d exp=0", glitch_cnt); end
`endif
    endtask

    // Bit 5 high for four scans, with an idle gap after scan 2 that must not lose counts.
    task automatic test_debounce();
        for (int s = 1; s <= 3; s++) begin
            scan(48'h20);
            n_checks++; if (stable_state !== 48'h0) begin n_fail++; $display("FAIL deb_hold_scan%0d got=%h exp=%h", s, stable_state, 48'h0); end
            n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL deb_nochg_scan%0d got=%b exp=0", s, changed); end
            if (s == 2) begin
                repeat (5) tick();
            end
        end
        scan(48'h20);
        n_checks++; if (stable_state !== 48'h20) begin n_fail++; $display("FAIL deb_flip got=%h exp=%h", stable_state, 48'h20); end
        n_checks++; if (rise_evt !== 48'h20) begin n_fail++; $display("FAIL deb_rise got=%h exp=%h", rise_evt, 48'h20); end
        n_checks++; if (fall_evt !== 48'h0) begin n_fail++; $display("FAIL deb_fall got=%h exp=%h", fall_evt, 48'h0); end
        n_checks++; if (changed !== 1'b1) begin n_fail++; $display("FAIL deb_changed got=%b exp=1", changed); end
        tick();
        n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL deb_changed_pulse got=%b exp=0", changed); end
    endtask

    // Bit 0: 1,1,0,1,1,1,1 with bit 5 held at its stable 1; irq enabled on bit 0 only.
    task automatic test_bounce_irq();
        logic [6:0] seq;
        seq = 7'b1111011;
        irq_mask = 48'h1;
        for (int s = 0; s < 6; s++) begin
            scan(48'h20 | {47'd0, seq[s]});
            n_checks++; if (stable_state !== 48'h20) begin n_fail++; $display("FAIL bounce_hold_scan%0d got=%h exp=%h", s + 1, stable_state, 48'h20); end
        end
        scan(48'h21);
        n_checks++; if (stable_state !== 48'h21) begin n_fail++; $display("FAIL bounce_flip got=%h exp=%h", stable_state, 48'h21); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_n1 got=%b exp=0", irq); end
`ifdef LIM_DEB_GLITCH_CNT_EN
        n_checks++; if (glitch_cnt !== 16'd1) begin n_fail++; $display("FAIL bounce_glitch got=%0d exp=1", glitch_cnt); end
`endif
        tick();
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_n2 got=%b exp=1", irq); end
        clr_we = 1'b1;
        clr_mask = 48'h1;
        tick();
        clr_we = 1'b0;
        clr_mask = '0;
        n_checks++; if (rise_evt !== 48'h20) begin n_fail++; $display("FAIL clr_rise got=%h exp=%h", rise_evt, 48'h20); end
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL clr_irq_n1 got=%b exp=1", irq); end
        tick();
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL clr_irq_n2 got=%b exp=0", irq); end
        irq_mask = '0;
    endtask

    // Bit 3 rises, then falls on the same cycle that clears its events: fall must survive.
    task automatic test_simultaneous();
        repeat (4) scan(48'h29);
        n_checks++; if (rise_evt !== 48'h28) begin n_fail++; $display("FAIL simul_rise3 got=%h exp=%h", rise_evt, 48'h28); end
        repeat (3) scan(48'h21);
        clr_we = 1'b1;
        clr_mask = 48'h8;
        scan(48'h21);
        clr_we = 1'b0;
        clr_mask = '0;
        n_checks++; if (stable_state !== 48'h21) begin n_fail++; $display("FAIL simul_stable got=%h exp=%h", stable_state, 48'h21); end
        n_checks++; if (fall_evt !== 48'h8) begin n_fail++; $display("FAIL simul_fall got=%h exp=%h", fall_evt, 48'h8); end
        n_checks++; if (rise_evt !== 48'h20) begin n_fail++; $display("FAIL simul_rise got=%h exp=%h", rise_evt, 48'h20); end
    endtask

    // Partial count on bit 10 is discarded by reset.
    task automatic test_reset_mid();
        repeat (3) scan(48'h400);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            scan(48'h400);
            n_checks++; if (stable_state !== 48'h0) begin n_fail++; $display("FAIL rstmid_hold_scan%0d got=%h exp=%h", s, stable_state, 48'h0); end
        end
        scan(48'h400);
        n_checks++; if (stable_state !== 48'h400) begin n_fail++; $display("FAIL rstmid_flip got=%h exp=%h", stable_state, 48'h400); end
        n_checks++; if (rise_evt !== 48'h400) begin n_fail++; $display("FAIL rstmid_rise got=%h exp=%h", rise_evt, 48'h400); end
        n_checks++; if (fall_evt !== 48'h0) begin n_fail++; $display("FAIL rstmid_fall got=%h exp=%h", fall_evt, 48'h0); end
    endtask

    // DEB_SCANS=1: a single differing scan flips every bit.
    task automatic test_deb1();
        b_valid = 1'b1;
        b_data  = 48'hFFFF_FFFF_FFFF;
        tick();
        b_valid = 1'b0;
        n_checks++; if (b_stable !== 48'hFFFF_FFFF_FFFF) begin n_fail++; $display("FAIL deb1_stable got=%h exp=%h", b_stable, 48'hFFFF_FFFF_FFFF); end
        n_checks++; if (b_rise !== 48'hFFFF_FFFF_FFFF) begin n_fail++; $display("FAIL deb1_rise got=%h exp=%h", b_rise, 48'hFFFF_FFFF_FFFF); end
        n_checks++; if (b_changed !== 1'b1) begin n_fail++; $display("FAIL deb1_changed got=%b exp=1", b_changed); end
    endtask

    initial begin
        #1;
        test_reset();
        test_debounce();
        test_bounce_irq();
        test_simultaneous();
        test_reset_mid();
        test_deb1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
